// File: rtl/alu_requester.sv
// Sequential requester for the 8-bit ALU: latches one operand set, waits a
// programmable settle time, captures result/flags, and chains via an accumulator.
module alu_requester #(
  parameter int unsigned ALU_LAT = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic [2:0] req_op,
  input  logic [7:0] req_a,
  input  logic [7:0] req_b,
  input  logic       req_use_acc,
  output logic [7:0] alu_a,
  output logic [7:0] alu_b,
  output logic [2:0] alu_op,
  output logic       alu_c_in,
  input  logic [7:0] alu_out,
  input  logic       alu_c_out,
  input  logic       alu_c_flag,
  input  logic       alu_zero,
  output logic       rsp_valid,
  input  logic       rsp_ready,
  output logic [7:0] rsp_data,
  output logic       rsp_c_out,
  output logic       rsp_c_flag,
  output logic       rsp_zero,
  output logic [7:0] acc,
  output logic [7:0] done_cnt
);

  localparam logic [3:0] LAT4 = 4'(ALU_LAT);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

  state_t     r_state;
  state_t     w_state_nxt;
  logic [3:0] r_cnt;
  logic       w_accept;
  logic       w_capture;
  logic       w_retire;

  logic [7:0] r_alu_a;
  logic [7:0] r_alu_b;
  logic [2:0] r_alu_op;
  logic [7:0] r_rsp_data;
  logic       r_rsp_c_out;
  logic       r_rsp_c_flag;
  logic       r_rsp_zero;
  logic [7:0] r_acc;
  logic [7:0] r_done_cnt;

  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    w_capture   = 1'b0;
    w_retire    = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (req_valid) begin
          w_accept    = 1'b1;
          w_state_nxt = S_WAIT;
        end
      end
      S_WAIT: begin
        if (r_cnt == 4'd1) begin
          w_capture   = 1'b1;
          w_state_nxt = S_RESP;
        end
      end
      S_RESP: begin
        if (rsp_ready) begin
          w_retire    = 1'b1;
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_accept)
        r_cnt <= LAT4;
      else if (r_state == S_WAIT)
        r_cnt <= r_cnt - 4'd1;
    end
  end

  // Operand A is taken from the accumulator as it stands at the accept edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_alu_a  <= '0;
      r_alu_b  <= '0;
      r_alu_op <= '0;
    end else if (w_accept) begin
      r_alu_a  <= req_use_acc ? r_acc : req_a;
      r_alu_b  <= req_b;
      r_alu_op <= req_op;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rsp_data   <= '0;
      r_rsp_c_out  <= 1'b0;
      r_rsp_c_flag <= 1'b0;
      r_rsp_zero   <= 1'b0;
      r_acc        <= '0;
    end else if (w_capture) begin
      r_rsp_data   <= alu_out;
      r_rsp_c_out  <= alu_c_out;
      r_rsp_c_flag <= alu_c_flag;
      r_rsp_zero   <= alu_zero;
      r_acc        <= alu_out;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      r_done_cnt <= '0;
    else if (w_retire)
      r_done_cnt <= r_done_cnt + 8'd1;
  end

  assign req_ready  = (r_state == S_IDLE);
  assign rsp_valid  = (r_state == S_RESP);
  assign alu_a      = r_alu_a;
  assign alu_b      = r_alu_b;
  assign alu_op     = r_alu_op;
  assign alu_c_in   = r_alu_op[0];
  assign rsp_data   = r_rsp_data;
  assign rsp_c_out  = r_rsp_c_out;
  assign rsp_c_flag = r_rsp_c_flag;
  assign rsp_zero   = r_rsp_zero;
  assign acc        = r_acc;
  assign done_cnt   = r_done_cnt;

endmodule

// File: tb/tb_alu_requester.sv
// Bench for alu_requester: three instances (ALU_LAT 1/3/4) each wired to a
// behavioural ALU; directed vectors, back-pressure, reset and random chaining.
module tb_alu_requester;

  localparam int NI = 3;
  localparam logic [NI-1:0][3:0] LATS = {4'd4, 4'd3, 4'd1};

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n;

  logic       req_valid [NI];
  logic       req_ready [NI];
  logic       req_use_acc [NI];
  logic [2:0] req_op [NI];
  logic [7:0] req_a [NI];
  logic [7:0] req_b [NI];
  logic [7:0] alu_a [NI];
  logic [7:0] alu_b [NI];
  logic [2:0] alu_op [NI];
  logic       alu_c_in [NI];
  logic [7:0] alu_out [NI];
  logic       alu_c_out [NI];
  logic       alu_c_flag [NI];
  logic       alu_zero [NI];
  logic       rsp_valid [NI];
  logic       rsp_ready [NI];
  logic [7:0] rsp_data [NI];
  logic       rsp_c_out [NI];
  logic       rsp_c_flag [NI];
  logic       rsp_zero [NI];
  logic [7:0] acc [NI];
  logic [7:0] done_cnt [NI];

  logic [7:0] exp_acc [NI];
  logic [7:0] exp_done [NI];
  int n_cmp = 0;
  int n_fail = 0;

  // Reference ALU: returns {c_out, c_flag(A>B), zero, out}
  function automatic logic [10:0] alu_model(input logic [7:0] a, input logic [7:0] b,
                                            input logic [2:0] op, input logic cin);
    logic [8:0] s;
    logic [7:0] o;
    logic       c;
    s = '0; o = '0; c = 1'b0;
    case (op)
      3'd0: begin s = {1'b0, a} + {1'b0, b} + {8'd0, cin}; o = s[7:0]; c = s[8]; end
      3'd1: begin s = {1'b0, a} + {1'b0, ~b} + {8'd0, cin}; o = s[7:0]; c = s[8]; end
      3'd2: o = a & b;
      3'd3: o = a | b;
      3'd4: o = a ^ b;
      3'd5: o = (a > b) ? 8'd1 : 8'd0;
      3'd6: begin o = {a[6:0], 1'b0}; c = a[7]; end
      default: begin o = {b[6:0], 1'b0}; c = b[7]; end
    endcase
    return {c, (a > b), (o == 8'd0), o};
  endfunction

  for (genvar g = 0; g < NI; g++) begin : g_dut
    alu_requester #(.ALU_LAT(int'(LATS[g]))) u_dut (
      .clk(clk), .rst_n(rst_n),
      .req_valid(req_valid[g]), .req_ready(req_ready[g]), .req_op(req_op[g]),
      .req_a(req_a[g]), .req_b(req_b[g]), .req_use_acc(req_use_acc[g]),
      .alu_a(alu_a[g]), .alu_b(alu_b[g]), .alu_op(alu_op[g]), .alu_c_in(alu_c_in[g]),
      .alu_out(alu_out[g]), .alu_c_out(alu_c_out[g]), .alu_c_flag(alu_c_flag[g]),
      .alu_zero(alu_zero[g]),
      .rsp_valid(rsp_valid[g]), .rsp_ready(rsp_ready[g]), .rsp_data(rsp_data[g]),
      .rsp_c_out(rsp_c_out[g]), .rsp_c_flag(rsp_c_flag[g]), .rsp_zero(rsp_zero[g]),
      .acc(acc[g]), .done_cnt(done_cnt[g])
    );
    assign {alu_c_out[g], alu_c_flag[g], alu_zero[g], alu_out[g]} =
      alu_model(alu_a[g], alu_b[g], alu_op[g], alu_c_in[g]);
  end

  task automatic chk(input string nm, input int unsigned act, input int unsigned exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One transaction on instance d; rsp_ready held low for 'stall' cycles once valid.
  task automatic run_txn(input int d, input logic [7:0] a, input logic [7:0] b,
                         input logic [2:0] op, input logic ua, input int stall,
                         output logic [7:0] data, output logic [2:0] flags,
                         output logic [7:0] aa);
    logic [7:0]  ea;
    logic [10:0] m;
    int n;
    chk("req_ready_idle", req_ready[d], 1);
    ea = ua ? exp_acc[d] : a;
    m  = alu_model(ea, b, op, op[0]);
    req_valid[d] = 1'b1; req_a[d] = a; req_b[d] = b; req_op[d] = op; req_use_acc[d] = ua;
    step();
    req_valid[d] = 1'b0;
    chk("req_ready_busy", req_ready[d], 0);
    chk("alu_op", alu_op[d], op);
    chk("alu_b", alu_b[d], b);
    chk("alu_c_in", alu_c_in[d], op[0]);
    aa = alu_a[d];
    n = 0;
    while (!rsp_valid[d] && n < 40) begin
      step();
      n++;
    end
    chk("latency", n, LATS[d]);
    data  = rsp_data[d];
    flags = {rsp_c_out[d], rsp_c_flag[d], rsp_zero[d]};
    for (int i = 0; i < stall; i++) begin
      if (i == 1) begin
        req_valid[d] = 1'b1; req_a[d] = ~a; req_op[d] = ~op; req_use_acc[d] = 1'b0;
      end
      step();
      req_valid[d] = 1'b0;
      chk("bp_rsp_valid", rsp_valid[d], 1);
      chk("bp_req_ready", req_ready[d], 0);
      chk("bp_rsp_data", rsp_data[d], data);
      chk("bp_rsp_flags", {rsp_c_out[d], rsp_c_flag[d], rsp_zero[d]}, flags);
      chk("bp_alu_a", alu_a[d], aa);
      chk("bp_alu_op", alu_op[d], op);
      chk("bp_acc", acc[d], m[7:0]);
    end
    rsp_ready[d] = 1'b1;
    step();
    rsp_ready[d] = 1'b0;
    exp_done[d] = exp_done[d] + 8'd1;
    exp_acc[d]  = m[7:0];
    chk("retire_rsp_valid", rsp_valid[d], 0);
    chk("retire_req_ready", req_ready[d], 1);
    chk("acc", acc[d], exp_acc[d]);
    chk("done_cnt", done_cnt[d], exp_done[d]);
  endtask

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic [2:0] op;
    logic       ua;
    logic [7:0] exp_alu_a;
    logic [7:0] exp_data;
    logic [2:0] exp_flags;   // {c_out, c_flag, zero}
  } vec_t;

  initial begin
    vec_t        vecs [5];
    logic [7:0]  data, aa, ea, ra, rb;
    logic [2:0]  flags, rop;
    logic        rua;
    logic [10:0] m;

    vecs[0] = '{8'd95,  8'd14,  3'b000, 1'b0, 8'd95,  8'd109, 3'b010};
    vecs[1] = '{8'd95,  8'd14,  3'b001, 1'b0, 8'd95,  8'd81,  3'b110};
    vecs[2] = '{8'd0,   8'd14,  3'b000, 1'b1, 8'd81,  8'd95,  3'b010};
    vecs[3] = '{8'h5A,  8'h5A,  3'b100, 1'b0, 8'h5A,  8'h00,  3'b001};
    vecs[4] = '{8'h80,  8'h00,  3'b110, 1'b0, 8'h80,  8'h00,  3'b111};

    rst_n = 1'b0;
    for (int i = 0; i < NI; i++) begin
      req_valid[i] = 1'b0; req_use_acc[i] = 1'b0; req_op[i] = '0;
      req_a[i] = '0; req_b[i] = '0; rsp_ready[i] = 1'b0;
      exp_acc[i] = '0; exp_done[i] = '0;
    end
    step();
    step();
    for (int i = 0; i < NI; i++) begin
      chk("rst_req_ready", req_ready[i], 1);
      chk("rst_rsp_valid", rsp_valid[i], 0);
      chk("rst_alu", {alu_a[i], alu_b[i], alu_op[i], alu_c_in[i]}, 0);
      chk("rst_rsp", {rsp_data[i], rsp_c_out[i], rsp_c_flag[i], rsp_zero[i]}, 0);
      chk("rst_acc_done", {acc[i], done_cnt[i]}, 0);
    end
    rst_n = 1'b1;
    step();

    // Directed vectors, ALU_LAT=1
    for (int i = 0; i < 5; i++) begin
      run_txn(0, vecs[i].a, vecs[i].b, vecs[i].op, vecs[i].ua, 0, data, flags, aa);
      chk("vec_alu_a", aa, vecs[i].exp_alu_a);
      chk("vec_data", data, vecs[i].exp_data);
      chk("vec_flags", flags, vecs[i].exp_flags);
    end

    // Back-pressure, ALU_LAT=3, with an ignored request pulse inside the stall
    run_txn(1, 8'd95, 8'd14, 3'b000, 1'b0, 5, data, flags, aa);
    chk("bp_data_val", data, 109);
    chk("bp_flags_val", flags, 3'b010);

    // Random chained traffic with random stalls, ALU_LAT=3
    for (int i = 0; i < 20; i++) begin
      ra = 8'($urandom); rb = 8'($urandom); rop = 3'($urandom); rua = 1'($urandom);
      ea = rua ? exp_acc[1] : ra;
      m  = alu_model(ea, rb, rop, rop[0]);
      run_txn(1, ra, rb, rop, rua, int'($urandom_range(0, 3)), data, flags, aa);
      chk("rnd3_alu_a", aa, ea);
      chk("rnd3_data", data, m[7:0]);
      chk("rnd3_flags", flags, m[10:8]);
    end

    // Reset two cycles into WAIT, ALU_LAT=4
    req_valid[2] = 1'b1; req_a[2] = 8'h33; req_b[2] = 8'h11; req_op[2] = 3'b011;
    req_use_acc[2] = 1'b0;
    step();
    req_valid[2] = 1'b0;
    step();
    step();
    chk("pre_rst_in_wait", {req_ready[2], rsp_valid[2]}, 0);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_req_ready", req_ready[2], 1);
    chk("mid_rst_rsp_valid", rsp_valid[2], 0);
    chk("mid_rst_alu", {alu_a[2], alu_b[2], alu_op[2], alu_c_in[2]}, 0);
    chk("mid_rst_rsp", {rsp_data[2], rsp_c_out[2], rsp_c_flag[2], rsp_zero[2]}, 0);
    chk("mid_rst_acc_done", {acc[2], done_cnt[2]}, 0);
    chk("mid_rst_done0", done_cnt[0], 0);
    for (int i = 0; i < NI; i++) begin
      exp_acc[i] = '0; exp_done[i] = '0;
    end
    step();
    rst_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      step();
      chk("post_rst_no_rsp", {rsp_valid[2], done_cnt[2]}, 0);
    end

    // 256 back-to-back random chained transactions, done_cnt wraps, ALU_LAT=1
    for (int i = 0; i < 256; i++) begin
      ra = 8'($urandom); rb = 8'($urandom); rop = 3'($urandom); rua = 1'($urandom);
      ea = rua ? exp_acc[0] : ra;
      m  = alu_model(ea, rb, rop, rop[0]);
      run_txn(0, ra, rb, rop, rua, 0, data, flags, aa);
      chk("wrap_alu_a", aa, ea);
      chk("wrap_data", data, m[7:0]);
      chk("wrap_flags", flags, m[10:8]);
    end
    chk("wrap_final_done", done_cnt[0], 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/alu_requester.md
# alu_requester

Sequential requester that drives the 8-bit ALU's operand/opcode port and returns its result and flags to a client over valid/ready handshakes. It sits between an instruction or control source and the combinational `ALU` instance, which the parent module wires to the `alu_*` ports. It keeps one transaction outstanding, holds the ALU inputs stable for a programmable settle time, and then captures the result. It also keeps an accumulator so that results can be chained without a round trip through the client.

## Interface
- `ALU_LAT`, default 1: number of cycles the ALU inputs are held before the result is captured. Legal range is 1..15.
- `clk`  in  1  clock; all state updates on the rising edge
- `rst_n`  in  1  asynchronous active-low reset
- `req_valid`  in  1  request valid
- `req_ready`  out  1  requester can accept a request
- `req_op`  in  3  ALU opcode
- `req_a`  in  8  operand A
- `req_b`  in  8  operand B
- `req_use_acc`  in  1  use the accumulator instead of `req_a` as operand A
- `alu_a`, `alu_b`  out  8 each  operands to the ALU
- `alu_op`  out  3  opcode to the ALU
- `alu_c_in`  out  1  carry-in to the ALU; always equal to `alu_op[0]`
- `alu_out`  in  8  ALU result
- `alu_c_out`, `alu_c_flag`, `alu_zero`  in  1 each  ALU flags
- `rsp_valid`  out  1  response valid
- `rsp_ready`  in  1  client accepts the response
- `rsp_data`  out  8  captured result
- `rsp_c_out`, `rsp_c_flag`, `rsp_zero`  out  1 each  captured flags
- `acc`  out  8  accumulator; holds the last captured result
- `done_cnt`  out  8  count of completed responses; wraps from 255 to 0

## Operation
- The FSM has three states:
  - IDLE: `req_ready`=1.
  - WAIT: the settle counter runs.
  - RESP: `rsp_valid`=1.
- IDLE to WAIT: on `req_valid`&&`req_ready`, latch the following and load the settle counter with `ALU_LAT`:
  - `alu_a` = `req_use_acc` ? `acc` : `req_a`
  - `alu_b` = `req_b`
  - `alu_op` = `req_op`
  - `alu_c_in` = `req_op[0]`
- WAIT: decrement the counter each cycle. At the edge where the counter equals 1:
  - capture `rsp_data`=`alu_out`, `rsp_c_out`, `rsp_c_flag`, `rsp_zero`;
  - set `acc`=`alu_out`;
  - go to RESP.
- RESP to IDLE: on `rsp_ready`. Increment `done_cnt` (mod 256) on that same edge.
- `alu_*` outputs hold their latched values through WAIT and RESP, and in IDLE they keep the last transaction's values until a new request is accepted.
- `rsp_*` outputs hold their captured values until the next capture. They are meaningful only while `rsp_valid`=1.
- `req_ready` and `rsp_valid` are decoded from the state register only; they are never combinational from the inputs.
- Opcode map, which the requester passes through to the ALU unmodified:
  - 000 add
  - 001 sub (A + ~B + 1)
  - 010 and
  - 011 or
  - 100 xor
  - 101 A>B
  - 110 A<<1
  - 111 B<<1
- Flags are captured for every opcode, whatever the opcode.
- Only one transaction is ever outstanding. Requests presented outside IDLE are ignored and not latched.

## Timing
- Reset, while `rst_n`=0, asynchronous:
  - state goes to IDLE, so `req_ready`=1;
  - `rsp_valid`=0;
  - `alu_a`, `alu_b`, `alu_op`, `alu_c_in`, `rsp_data`, `rsp_c_out`, `rsp_c_flag`, `rsp_zero`, `acc` and `done_cnt` all go to 0.
- Latency for a request accepted at edge k:
  - `alu_*` are valid after edge k;
  - the capture is at edge k+`ALU_LAT`;
  - `rsp_valid` is high from edge k+`ALU_LAT`.
- Minimum time in RESP is one cycle. With `rsp_ready` held high, transactions complete every `ALU_LAT`+2 cycles.
- Back-pressure: while `rsp_valid`=1 and `rsp_ready`=0, every `rsp_*`, `acc` and `alu_*` output stays stable and `req_ready`=0.
- Reset asserted mid-WAIT or mid-RESP: the transaction is discarded, no response is produced, and `done_cnt` is not incremented.
- `req_use_acc` with a chained request reads `acc` as it stands at the accept edge, which is the result of the previous completed transaction. If nothing has completed since reset, `acc` is 0.
- An `ALU_LAT` value outside 1..15 is unsupported. The bench must only use legal values.

## Test plan
- Add, `ALU_LAT`=1: a=95, b=14, op=000 → `rsp_valid` 1 cycle after accept, `rsp_data`=109, `c_out`=0, `c_flag`=1, `zero`=0, `done_cnt`=1.
- Sub then chain:
  - a=95, b=14, op=001 → `alu_c_in`=1, `rsp_data`=81, `c_out`=1;
  - next request `req_use_acc`=1, b=14, op=000 → `alu_a`=81, `rsp_data`=95.
- Zero flag: a=b=0x5A, op=100 → `rsp_data`=0, `zero`=1. Then a=0x80, op=110 → `rsp_data`=0x00, `zero`=1.
- Back-pressure, `ALU_LAT`=3:
  - hold `rsp_ready`=0 for 5 cycles → `rsp_valid` rises 3 cycles after accept;
  - `rsp_*` stay stable and `req_ready`=0 throughout;
  - a `req_valid` pulse during this window is ignored;
  - releasing `rsp_ready` returns to IDLE in 1 cycle.
- Reset mid-WAIT, `ALU_LAT`=4: assert `rst_n`=0 two cycles after accept → all outputs are 0 immediately, `req_ready`=1, and no response appears after release.
- Wrap: run 256 back-to-back transactions → `done_cnt` goes 255→0, with no dropped or duplicated responses against the bench's reference ALU model.
